// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- multi-ported register file with a per-register busy scoreboard
//
// Holds NREGS registers of WIDTH bits. Each register has a busy bit that marks
// a pending producer. A claim sets the bit, and a write to that register clears
// it. Register 0 reads as zero and is never written or marked busy. Reads are
// combinational on NRD independent ports.
//
// Optional feature:
//   REGFILE_SB_BYPASS_EN  - when defined, a write in the current cycle is
//                           forwarded to any read port that addresses the same
//                           register. The busy bit seen on that port is cleared
//                           in the same way.
//
// Parameters:
//   WIDTH  - data width of each register
//   NREGS  - register count (power of two, >= 2)
//   NRD    - number of read ports (>= 1)
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   raddr       in   NRD*AW   read addresses, port i at [i*AW +: AW]
//   rdata       out  NRD*WIDTH read data, port i at [i*WIDTH +: WIDTH]
//   rbusy       out  NRD      busy flag of the register addressed on port i
//   we          in   write enable
//   waddr       in   write address
//   wdata       in   write data
//   claim       in   mark claim_addr as having a pending producer
//   claim_addr  in   register being claimed
//   nbusy       out  AW+1     registered count of busy registers
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 3,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 claim,
    input  logic [AW-1:0]        claim_addr,
    output logic [AW:0]          nbusy
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      nbusy_q;
    logic [AW:0]      nbusy_d;
    // armed_q stays low through reset and the first edge after release. That
    // edge therefore ignores any write or claim that is presented with it.
    logic             armed_q;
    logic             armed_d;
    logic             wr_en;
    logic             cl_en;
    logic [AW-1:0]    ra;

    always_comb begin
        armed_d = 1'b1;
        wr_en   = armed_q && we && (waddr != '0);
        cl_en   = armed_q && claim && (claim_addr != '0);
        regs_d  = regs_q;
        busy_d  = busy_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
            busy_d[waddr] = 1'b0;
        end
        // The claim is applied after the retire, so a new producer wins when
        // both events target the same register.
        if (cl_en) begin
            busy_d[claim_addr] = 1'b1;
        end
        nbusy_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            nbusy_d = nbusy_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            nbusy_q <= '0;
            armed_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            rdata[i*WIDTH +: WIDTH] = (ra == '0) ? '0 : regs_q[ra];
            rbusy[i] = busy_q[ra];
`ifdef REGFILE_SB_BYPASS_EN
            // wr_en already excludes address 0, so register 0 is never forwarded.
            if (wr_en && (waddr == ra)) begin
                rdata[i*WIDTH +: WIDTH] = wdata;
                rbusy[i] = cl_en && (claim_addr == waddr);
            end
`endif
        end
    end

    assign nbusy = nbusy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb -- scoreboard testbench for regfile_sb
//
// The driver applies one set of inputs per cycle, shortly after the rising
// edge. It pushes the expected outputs for that cycle into a queue. The
// expected values come from a plain array model of the register file and its
// busy flags. A separate monitor pops one entry at each falling edge and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH-1:0]     wdata;
    logic                 claim;
    logic [AW-1:0]        claim_addr;
    logic [AW:0]          nbusy;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .claim      (claim),
        .claim_addr (claim_addr),
        .nbusy      (nbusy)
    );

    typedef struct {
        logic [NRD*WIDTH-1:0] rdata;
        logic [NRD-1:0]       rbusy;
        logic [AW:0]          nbusy;
        int                   cyc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: register contents and busy flags.
    logic [WIDTH-1:0] mem   [NREGS];
    bit               mbusy [NREGS];
    bit               m_skip;

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) begin
            mem[i]   = '0;
            mbusy[i] = 1'b0;
        end
    endfunction

    // Apply the edge that just happened, using the inputs held across it.
    function automatic void commit();
        if (reset_n !== 1'b1) return;
        if (m_skip) begin
            m_skip = 1'b0;
            return;
        end
        if (we && waddr != 0) begin
            mem[waddr]   = wdata;
            mbusy[waddr] = 1'b0;
        end
        if (claim && claim_addr != 0) mbusy[claim_addr] = 1'b1;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   a;
        int   cnt;
        e.cyc   = cyc;
        e.rdata = '0;
        e.rbusy = '0;
        e.nbusy = '0;
        if (reset_n !== 1'b1) return e;
        for (int i = 0; i < NRD; i++) begin
            a = int'(raddr[i*AW +: AW]);
            if (BYP && !m_skip && we && a != 0 && int'(waddr) == a) begin
                e.rdata[i*WIDTH +: WIDTH] = wdata;
                e.rbusy[i] = claim && (claim_addr == waddr);
            end else begin
                e.rdata[i*WIDTH +: WIDTH] = (a == 0) ? '0 : mem[a];
                e.rbusy[i] = mbusy[a];
            end
        end
        cnt = 0;
        for (int r = 0; r < NREGS; r++) cnt += int'(mbusy[r]);
        e.nbusy = (AW+1)'(cnt);
        return e;
    endfunction

    function automatic logic [NRD*AW-1:0] ports(input int a0, input int a1, input int a2);
        logic [AW-1:0] p0, p1, p2;
        p0 = AW'(a0);
        p1 = AW'(a1);
        p2 = AW'(a2);
        return {p2, p1, p0};
    endfunction

    task automatic step(input logic rn, input logic w, input int wa, input logic [WIDTH-1:0] wd,
                        input logic c, input int ca, input logic [NRD*AW-1:0] ra);
        @(posedge clk);
        #1;
        cyc++;
        commit();
        if (reset_n !== 1'b1 && rn) m_skip = 1'b1;
        if (!rn) begin
            model_clear();
            m_skip = 1'b0;
        end
        reset_n    = rn;
        we         = w;
        waddr      = AW'(wa);
        wdata      = wd;
        claim      = c;
        claim_addr = AW'(ca);
        raddr      = ra;
        expq.push_back(predict());
    endtask

    task automatic idle_read(input int a0, input int a1, input int a2);
        step(1'b1, 1'b0, 0, '0, 1'b0, 0, ports(a0, a1, a2));
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                for (int i = 0; i < NRD; i++) begin
                    total++;
                    if (rdata[i*WIDTH +: WIDTH] !== mon_e.rdata[i*WIDTH +: WIDTH]) begin
                        bad++;
                        $display("FAIL rdata%0d cyc=%0d got=%h exp=%h", i, mon_e.cyc,
                                 rdata[i*WIDTH +: WIDTH], mon_e.rdata[i*WIDTH +: WIDTH]);
                    end
                    total++;
                    if (rbusy[i] !== mon_e.rbusy[i]) begin
                        bad++;
                        $display("FAIL rbusy%0d cyc=%0d got=%b exp=%b", i, mon_e.cyc,
                                 rbusy[i], mon_e.rbusy[i]);
                    end
                end
                total++;
                if (nbusy !== mon_e.nbusy) begin
                    bad++;
                    $display("FAIL nbusy cyc=%0d got=%0d exp=%0d", mon_e.cyc, nbusy, mon_e.nbusy);
                end
            end
        end
    end

    // Driver
    initial begin
        int k;
        logic rn;
        reset_n    = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        claim      = 1'b0;
        claim_addr = '0;
        raddr      = '0;
        m_skip     = 1'b0;
        model_clear();

        // Reset held with activity on the inputs: everything must read zero.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, i + 1, $urandom, 1'b1, i + 2, ports(i + 1, i + 2, i + 3));

        // Release with a write and a claim on the same edge. Both are ignored.
        step(1'b1, 1'b1, 6, 32'h1111_1111, 1'b1, 6, ports(6, 0, 6));
        // Sweep all addresses on all ports.
        for (int a = 0; a < NREGS; a++) idle_read(a, (a + 11) % NREGS, (a + 23) % NREGS);

        // Write r5, read back. Write to r0 is ignored.
        step(1'b1, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, ports(0, 0, 0));
        step(1'b1, 1'b1, 0, 32'h0000_1234, 1'b0, 0, ports(5, 0, 0));
        idle_read(5, 0, 0);

        // Claim r7, then retire it with a write.
        step(1'b1, 1'b0, 0, '0, 1'b1, 7, ports(0, 0, 0));
        idle_read(0, 7, 0);
        step(1'b1, 1'b1, 7, 32'h55, 1'b0, 0, ports(0, 7, 0));
        idle_read(0, 7, 0);

        // Claim and write r9 in the same cycle: busy stays set, data updates.
        step(1'b1, 1'b1, 9, 32'hAA, 1'b1, 9, ports(9, 9, 9));
        idle_read(9, 9, 9);

        // Write to a busy r3 while port 2 reads it (forwarding if enabled).
        step(1'b1, 1'b0, 0, '0, 1'b1, 3, ports(0, 0, 0));
        step(1'b1, 1'b1, 3, 32'h77, 1'b0, 0, ports(0, 0, 3));
        idle_read(0, 0, 3);
        // Claim and write of the same register while it is also being read.
        step(1'b1, 1'b1, 3, 32'h88, 1'b1, 3, ports(3, 0, 3));
        idle_read(3, 3, 3);

        // Claim r1..r4 with a reset arriving mid-sequence.
        step(1'b1, 1'b0, 0, '0, 1'b1, 1, ports(1, 2, 3));
        step(1'b1, 1'b0, 0, '0, 1'b1, 2, ports(1, 2, 3));
        step(1'b0, 1'b1, 5, 32'hFFFF_FFFF, 1'b1, 3, ports(1, 2, 5));
        step(1'b0, 1'b0, 0, '0, 1'b1, 4, ports(1, 2, 3));
        step(1'b1, 1'b0, 0, '0, 1'b1, 4, ports(1, 2, 4));
        idle_read(1, 4, 9);

        // Randomized traffic, mostly on a small address window to force overlap.
        for (int n = 0; n < 1500; n++) begin
            int wa, ca, a0, a1, a2, span;
            span = ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7;
            wa = $urandom_range(0, span);
            ca = $urandom_range(0, span);
            a0 = $urandom_range(0, span);
            a1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, span);
            a2 = $urandom_range(0, span);
            rn = ($urandom_range(0, 199) != 0);
            step(rn, 1'($urandom_range(0, 1)), wa, $urandom,
                 1'($urandom_range(0, 1)), ca, ports(a0, a1, a2));
        end
        idle_read(1, 2, 3);

        k = 0;
        while (expq.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        if (expq.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 The block SHALL have parameter NREGS, default 32, register count, power of two, at least 2; AW = log2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 3, number of read ports, at least 1.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port raddr, input, NRD*AW, read addresses, with port i at bits [i*AW +: AW].
REQ-007 The block SHALL have port rdata, output, NRD*WIDTH, read data, with port i at bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port rbusy, output, NRD, which is 1 when the register addressed on port i has a pending producer.
REQ-009 The block SHALL have port we, input, 1, write enable.
REQ-010 The block SHALL have port waddr, input, AW, write address.
REQ-011 The block SHALL have port wdata, input, WIDTH, write data.
REQ-012 The block SHALL have port claim, input, 1, which marks claim_addr as having a pending producer.
REQ-013 The block SHALL have port claim_addr, input, AW, destination register being claimed.
REQ-014 The block SHALL have port nbusy, output, AW+1, count of registers currently marked busy.

Function
REQ-015 Register storage SHALL be NREGS x WIDTH flops; a write SHALL take effect on the clk edge where we=1, and the new value SHALL be visible on a non-bypassed read in the following cycle.
REQ-016 Register 0 SHALL read as zero, SHALL never be written and SHALL never be busy; writes and claims to address 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational from raddr with zero latency; all NRD ports SHALL be independent and may address the same register.
REQ-018 The scoreboard SHALL hold one busy bit per register; claim=1 SHALL set busy[claim_addr] at the edge, and we=1 SHALL clear busy[waddr] at the edge.
REQ-019 When claim and we target the same nonzero register in the same cycle, busy SHALL end set: a new producer overrides retirement. The data write SHALL still occur.
REQ-020 rbusy[i] SHALL equal the registered busy bit of raddr[i], except as modified by REQ-027.
REQ-021 A write to a register that is not busy SHALL be legal and SHALL update data; busy SHALL remain 0.
REQ-022 A claim on an already-busy register SHALL leave it busy; no nesting depth is tracked.
REQ-023 nbusy SHALL be a registered population count of the busy bits, updated in the same edge as the bits themselves, and SHALL never exceed NREGS-1.

Reset
REQ-024 reset_n=0 SHALL asynchronously clear all registers to 0, all busy bits to 0 and nbusy to 0; rdata SHALL read 0 and rbusy SHALL read 0 while reset is asserted.
REQ-025 A claim or write presented on the edge where reset_n deasserts SHALL be ignored; the first effective edge SHALL be the one after deassertion.

Configuration
REQ-026 Macro REGFILE_SB_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-027 With REGFILE_SB_BYPASS_EN defined: when we=1 and waddr==raddr[i]!=0, rdata[i] SHALL equal wdata, and rbusy[i] SHALL be 0 unless claim=1 with claim_addr==waddr in the same cycle.
REQ-028 Without REGFILE_SB_BYPASS_EN: rdata and rbusy SHALL reflect only registered state; the written value and busy clear SHALL appear one cycle later.

Verification
REQ-029 Reset then read all addresses on all ports -> rdata=0, rbusy=0, nbusy=0.
REQ-030 Write r5=0xDEADBEEF, then next cycle raddr0=5 -> rdata0=0xDEADBEEF; we=1 to r0 with 0x1234 -> r0 reads 0.
REQ-031 Claim r7, next cycle raddr1=7 -> rbusy1=1, nbusy=1; write r7=0x55 -> next cycle rbusy1=0, nbusy=0.
REQ-032 Same cycle: claim r9, we r9=0xAA -> next cycle r9 busy=1, data=0xAA, nbusy=1.
REQ-033 Bypass build: r3 busy, we r3=0x77 with raddr2=3 in the same cycle -> rdata2=0x77, rbusy2=0; non-bypass build -> old data and rbusy2=1 that cycle.
REQ-034 Claim r1..r4, assert reset_n=0 mid-sequence -> immediate rdata=0, rbusy=0, nbusy=0.
